// File: rtl/fb_write_sched.sv
// Write-port scheduler for the dual-half framebuffer: paint pixel writes take
// priority, and a built-in sequencer sweeps both halves with a fill colour.
module fb_write_sched #(
    parameter int DATA_W  = 12,
    parameter int HALF_AW = 11,
    parameter int PIX_AW  = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              paint_req,
    input  logic [PIX_AW-1:0] paint_addr,
    input  logic [DATA_W-1:0] paint_wdata,
    output logic              paint_gnt,
    input  logic              clear_req,
    input  logic [DATA_W-1:0] clear_color,
    output logic              clear_busy,
    output logic              clear_done,
    output logic              wr0,
    output logic              wr1,
    output logic [HALF_AW-1:0] waddr,
    output logic [DATA_W-1:0] wdata
);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t              state, state_n;
    logic [HALF_AW-1:0]  cnt, cnt_n;
    logic [DATA_W-1:0]   color_reg, color_n;
    logic                fin, fin_n;
    logic                gnt_n, busy_n, done_n, wr0_n, wr1_n;
    logic [HALF_AW-1:0]  waddr_n;
    logic [DATA_W-1:0]   wdata_n;
    logic                paint_slot, clear_slot, accept;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        color_n = color_reg;
        fin_n   = 1'b0;
        gnt_n   = 1'b0;
        wr0_n   = 1'b0;
        wr1_n   = 1'b0;
        waddr_n = waddr;
        wdata_n = wdata;
        busy_n  = clear_busy;
        done_n  = 1'b0;

        // Requiring paint_gnt=0 leaves every other cycle free for the sweep.
        paint_slot = paint_req && !paint_gnt;
        clear_slot = !paint_slot && (state == CLEAR);
        // Busy stays high through the trailing done-pending cycle, so a
        // request landing there or on the done pulse is dropped.
        accept     = (state == IDLE) && clear_req && !clear_busy && !clear_done;

        if (paint_slot) begin
            gnt_n   = 1'b1;
            wr0_n   = ~paint_addr[PIX_AW-1];
            wr1_n   = paint_addr[PIX_AW-1];
            waddr_n = paint_addr[HALF_AW-1:0];
            wdata_n = paint_wdata;
        end else if (clear_slot) begin
            wr0_n   = 1'b1;
            wr1_n   = 1'b1;
            waddr_n = cnt;
            wdata_n = color_reg;
            cnt_n   = cnt + 1'b1;
            if (cnt == {HALF_AW{1'b1}}) begin
                state_n = IDLE;
                fin_n   = 1'b1;
            end
        end

        if (accept) begin
            state_n = CLEAR;
            color_n = clear_color;
            cnt_n   = '0;
            busy_n  = 1'b1;
        end

        if (fin) begin
            busy_n = 1'b0;
            done_n = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            color_reg  <= '0;
            fin        <= 1'b0;
            paint_gnt  <= 1'b0;
            clear_busy <= 1'b0;
            clear_done <= 1'b0;
            wr0        <= 1'b0;
            wr1        <= 1'b0;
            waddr      <= '0;
            wdata      <= '0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            color_reg  <= color_n;
            fin        <= fin_n;
            paint_gnt  <= gnt_n;
            clear_busy <= busy_n;
            clear_done <= done_n;
            wr0        <= wr0_n;
            wr1        <= wr1_n;
            waddr      <= waddr_n;
            wdata      <= wdata_n;
        end
    end

endmodule

// File: tb/tb_fb_write_sched.sv
// Directed bench for fb_write_sched: paint grants, full clear sweeps, clear
// interleaved with paint, ignored re-requests and reset mid-sweep.
module tb_fb_write_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        paint_req;
    logic [11:0] paint_addr;
    logic [11:0] paint_wdata;
    logic        paint_gnt;
    logic        clear_req;
    logic [11:0] clear_color;
    logic        clear_busy;
    logic        clear_done;
    logic        wr0, wr1;
    logic [10:0] waddr;
    logic [11:0] wdata;

    fb_write_sched dut (
        .clk(clk), .rst(rst),
        .paint_req(paint_req), .paint_addr(paint_addr), .paint_wdata(paint_wdata),
        .paint_gnt(paint_gnt),
        .clear_req(clear_req), .clear_color(clear_color),
        .clear_busy(clear_busy), .clear_done(clear_done),
        .wr0(wr0), .wr1(wr1), .waddr(waddr), .wdata(wdata)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Per-phase statistics gathered by step()
    int          cyc, busy_cnt, done_cnt, clear_wr, pgnt, order_err, ovl_err;
    logic [10:0] exp_caddr;
    logic [11:0] clr_color;
    int          hits [2048];
    int          ds, bad;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic clr_stats();
        cyc = 0; busy_cnt = 0; done_cnt = 0; clear_wr = 0; pgnt = 0;
        order_err = 0; ovl_err = 0; exp_caddr = '0;
        for (int i = 0; i < 2048; i++) hits[i] = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (clear_busy) busy_cnt++;
        if (clear_done) done_cnt++;
        if (wr0 && wr1) begin
            clear_wr++;
            if (waddr !== exp_caddr || wdata !== clr_color) order_err++;
            exp_caddr = exp_caddr + 11'd1;
            hits[waddr]++;
            if (paint_gnt) ovl_err++;
        end
        if (paint_gnt) begin
            pgnt++;
            if (wr0 == wr1) ovl_err++;
        end
    endtask

    task automatic wait_done(input int max, output int dstep);
        int n = 0;
        dstep = -1;
        while (!clear_done && n < max) begin
            step();
            n++;
        end
        if (clear_done) dstep = cyc;
    endtask

    task automatic count_bad(output int b);
        b = 0;
        for (int i = 0; i < 2048; i++) if (hits[i] != 1) b++;
    endtask

    initial begin
        rst = 1'b1; paint_req = 1'b0; paint_addr = '0; paint_wdata = '0;
        clear_req = 1'b0; clear_color = '0; clr_color = '0;
        clr_stats();
        repeat (3) step();
        rst = 1'b0;
        chk("rst_gnt", 32'(paint_gnt), 0);
        chk("rst_busy", 32'(clear_busy), 0);
        chk("rst_done", 32'(clear_done), 0);
        chk("rst_wr", 32'({wr0, wr1}), 0);
        chk("rst_waddr", 32'(waddr), 0);
        chk("rst_wdata", 32'(wdata), 0);

        // single paint to upper half
        paint_req = 1'b1; paint_addr = 12'h835; paint_wdata = 12'hF00;
        step();
        paint_req = 1'b0;
        chk("p1_gnt", 32'(paint_gnt), 1);
        chk("p1_wr1", 32'(wr1), 1);
        chk("p1_wr0", 32'(wr0), 0);
        chk("p1_waddr", 32'(waddr), 32'h035);
        chk("p1_wdata", 32'(wdata), 32'hF00);
        step();
        chk("p1_gnt_off", 32'(paint_gnt), 0);
        chk("p1_wr1_off", 32'(wr1), 0);
        chk("p1_waddr_hold", 32'(waddr), 32'h035);
        chk("p1_wdata_hold", 32'(wdata), 32'hF00);

        // held request: alternate-cycle grants
        clr_stats();
        paint_req = 1'b1; paint_addr = 12'h7FF; paint_wdata = 12'h0AA;
        repeat (6) step();
        paint_req = 1'b0;
        chk("p6_grants", 32'(pgnt), 3);
        chk("p6_ovl", 32'(ovl_err), 0);
        step();
        chk("p6_gnt_off", 32'(paint_gnt), 0);

        // full clear, no paint; a clear_req on the done cycle is ignored
        clr_stats();
        clr_color = 12'h0F0; clear_color = 12'h0F0; clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        chk("c_accept_busy", 32'(clear_busy), 1);
        chk("c_accept_nowr", 32'({wr0, wr1}), 0);
        wait_done(3000, ds);
        chk("c_done_step", 32'(ds), 2050);
        chk("c_writes", 32'(clear_wr), 2048);
        chk("c_order", 32'(order_err), 0);
        chk("c_busy_cycles", 32'(busy_cnt), 2049);
        count_bad(bad);
        chk("c_each_once", 32'(bad), 0);
        clear_req = 1'b1; clear_color = 12'hFFF;
        step();
        clear_req = 1'b0;
        chk("c_done_pulse", 32'(clear_done), 0);
        chk("c_req_on_done_ignored", 32'(clear_busy), 0);
        repeat (2) step();
        chk("c_single_done", 32'(done_cnt), 1);
        chk("c_busy_total", 32'(busy_cnt), 2049);
        chk("c_idle_wr", 32'({wr0, wr1}), 0);

        // clear with continuous paint traffic
        clr_stats();
        clr_color = 12'h00F; clear_color = 12'h00F; clear_req = 1'b1;
        paint_req = 1'b1; paint_addr = 12'h005; paint_wdata = 12'hABC;
        step();
        clear_req = 1'b0;
        chk("cp_accept_gnt", 32'(paint_gnt), 1);
        chk("cp_accept_busy", 32'(clear_busy), 1);
        wait_done(6000, ds);
        paint_req = 1'b0;
        chk("cp_done_step", 32'(ds), 4097);
        chk("cp_writes", 32'(clear_wr), 2048);
        chk("cp_order", 32'(order_err), 0);
        chk("cp_paint_grants", 32'(pgnt), 2049);
        chk("cp_no_overlap", 32'(ovl_err), 0);
        chk("cp_busy_cycles", 32'(busy_cnt), 4096);
        count_bad(bad);
        chk("cp_each_once", 32'(bad), 0);
        repeat (2) step();

        // second clear_req at word 100 is ignored
        clr_stats();
        clr_color = 12'h321; clear_color = 12'h321; clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        repeat (100) step();
        chk("r_word99", 32'(waddr), 99);
        clear_req = 1'b1; clear_color = 12'hEEE;
        step();
        clear_req = 1'b0;
        chk("r_no_restart", 32'(waddr), 100);
        wait_done(3000, ds);
        chk("r_done_step", 32'(ds), 2050);
        chk("r_writes", 32'(clear_wr), 2048);
        chk("r_order", 32'(order_err), 0);
        repeat (3) step();
        chk("r_single_done", 32'(done_cnt), 1);
        chk("r_busy_low", 32'(clear_busy), 0);

        // reset at word 500, then a fresh clear from address 0
        clr_stats();
        clr_color = 12'h456; clear_color = 12'h456; clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        repeat (500) step();
        chk("x_word499", 32'(waddr), 499);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("x_wr_off", 32'({wr0, wr1}), 0);
        chk("x_busy_off", 32'(clear_busy), 0);
        chk("x_done_off", 32'(clear_done), 0);
        repeat (5) step();
        chk("x_no_done", 32'(done_cnt), 0);
        chk("x_writes", 32'(clear_wr), 500);
        clr_stats();
        clr_color = 12'h123; clear_color = 12'h123; clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        step();
        chk("x_restart_wr", 32'({wr0, wr1}), 3);
        chk("x_restart_addr", 32'(waddr), 0);
        chk("x_restart_data", 32'(wdata), 32'h123);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
